// File: rtl/ram_be_pipe.sv
// ram_be_pipe: single-port-per-direction RAM with per-lane write enables,
// a 1- or 2-cycle registered read path, selectable read-during-write
// behaviour and an optional zero sweep after reset.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - asynchronous active-high reset
//   w_en     - write request
//   w_be     - per-lane write enable, bit i covers w_data[i*BYTE_W +: BYTE_W]
//   w_addr   - write address (writes at or beyond MEM_DEPTH are dropped)
//   w_data   - write data
//   r_en     - read request
//   r_addr   - read address (reads at or beyond MEM_DEPTH return zero)
//   r_data   - registered read data, holds between results
//   r_valid  - one-cycle strobe marking a new r_data value
//   busy     - high while the post-reset clear sweep runs; requests ignored
module ram_be_pipe #(
  parameter int    MEM_WIDTH      = 16,
  parameter int    MEM_DEPTH      = 256,
  parameter int    BYTE_W         = 8,
  parameter int    RD_LATENCY     = 1,
  parameter int    RDW_MODE       = 0,
  parameter int    CLEAR_ON_RESET = 0,
  parameter string INIT_FILE      = "",
  localparam int   LANES          = MEM_WIDTH / BYTE_W,
  localparam int   ADDR_WIDTH     = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [LANES-1:0]      w_be,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [MEM_WIDTH-1:0]  w_data,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [MEM_WIDTH-1:0]  r_data,
  output logic                  r_valid,
  output logic                  busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
  // One extra bit so the range compare also works when MEM_DEPTH is 2**N.
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [MEM_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  state_t                state_reg;
  logic                  busy_reg;
  logic [ADDR_WIDTH-1:0] clr_cnt_reg;

  logic                  w_ok;
  logic                  r_ok;
  logic                  r_in_range;
  logic                  w_hit;
  logic [MEM_WIDTH-1:0]  mem_rd;
  logic [MEM_WIDTH-1:0]  fwd_word;
  logic [MEM_WIDTH-1:0]  rd_word;

  logic                  s1_valid_reg;
  logic [MEM_WIDTH-1:0]  s1_data_reg;

  // Clear sweep controller. busy_reg tracks the CLEAR state exactly so the
  // request gating below sees a registered signal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= RESET_STATE;
      busy_reg    <= (RESET_STATE == CLEAR);
      clr_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          busy_reg <= 1'b0;
        end
        CLEAR: begin
          if (clr_cnt_reg == LAST_ADDR) begin
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            clr_cnt_reg <= '0;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign w_ok       = w_en && !busy_reg && ({1'b0, w_addr} < DEPTH_L);
  assign r_ok       = r_en && !busy_reg;
  assign r_in_range = ({1'b0, r_addr} < DEPTH_L);

  // Memory array: no reset so it maps onto block RAM. The clear sweep owns
  // the write port while busy.
  always_ff @(posedge clk) begin
    if (busy_reg) begin
      mem[clr_cnt_reg] <= '0;
    end else if (w_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_be[i]) begin
          mem[w_addr][i*BYTE_W +: BYTE_W] <= w_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign mem_rd = mem[r_addr];

  // Write-first bypass: enabled lanes of a same-address write replace the
  // stored lanes; in read-first mode the stored word passes through.
  assign w_hit = (RDW_MODE != 0) && w_ok && (w_addr == r_addr);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : gen_fwd
      assign fwd_word[gi*BYTE_W +: BYTE_W] = (w_hit && w_be[gi])
                                           ? w_data[gi*BYTE_W +: BYTE_W]
                                           : mem_rd[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  assign rd_word = r_in_range ? fwd_word : '0;

  // First read stage; its data only moves on an accepted read so the
  // single-stage output holds between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      s1_valid_reg <= r_ok;
      if (r_ok) begin
        s1_data_reg <= rd_word;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : gen_lat2
      logic                 s2_valid_reg;
      logic [MEM_WIDTH-1:0] s2_data_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid_reg <= 1'b0;
          s2_data_reg  <= '0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          if (s1_valid_reg) begin
            s2_data_reg <= s1_data_reg;
          end
        end
      end

      assign r_data  = s2_data_reg;
      assign r_valid = s2_valid_reg;
    end else begin : gen_lat1
      assign r_data  = s1_data_reg;
      assign r_valid = s1_valid_reg;
    end
  endgenerate

  assign busy = busy_reg;

endmodule

// File: doc/ram_be_pipe.md
RAM_BE_PIPE -- requirements
Module: ram_be_pipe

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, number of words; need not be a power of two.
REQ-003 SHALL have parameter BYTE_W, default 8, write-lane width; MEM_WIDTH SHALL be an integer multiple of BYTE_W; LANES = MEM_WIDTH/BYTE_W.
REQ-004 SHALL have parameter RD_LATENCY, default 1, legal values 1 or 2; cycles from r_en to r_data/r_valid.
REQ-005 SHALL have parameter RDW_MODE, default 0; 0 = read-first (old data), 1 = write-first (new data) on same-address read/write.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 0; 1 = zero every word after reset.
REQ-007 SHALL have parameter INIT_FILE, default "", hex image loaded at time zero only when non-empty and CLEAR_ON_RESET=0.
REQ-008 SHALL derive ADDR_WIDTH = $clog2(MEM_DEPTH) as a localparam.
REQ-009 clk  input  1  single clock; all state updates on rising edge.
REQ-010 rst  input  1  asynchronous, active-high reset.
REQ-011 w_en  input  1  write request.
REQ-012 w_be  input  LANES  per-lane write enable; bit i covers w_data[i*BYTE_W +: BYTE_W].
REQ-013 w_addr  input  ADDR_WIDTH  write address.
REQ-014 w_data  input  MEM_WIDTH  write data.
REQ-015 r_en  input  1  read request.
REQ-016 r_addr  input  ADDR_WIDTH  read address.
REQ-017 r_data  output  MEM_WIDTH  registered read data.
REQ-018 r_valid  output  1  high for exactly one cycle when r_data carries a new read result.
REQ-019 busy  output  1  high while clear sequence runs; requests ignored.

Function
REQ-020 Write: w_en=1 and busy=0 at a rising edge SHALL update only lanes with w_be[i]=1 at w_addr; other lanes keep old contents.
REQ-021 w_en=1 with w_be all zero SHALL leave memory unchanged.
REQ-022 Read: r_en=1 and busy=0 sampled at edge N SHALL present data at edge N+RD_LATENCY with r_valid=1 for that one cycle.
REQ-023 RD_LATENCY=2 SHALL add one output register stage; back-to-back reads every cycle SHALL be supported at full throughput for both latencies.
REQ-024 r_data SHALL hold its last value when no read result is delivered; r_valid SHALL be 0 then.
REQ-025 Same-address read and write in one cycle: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns word with enabled lanes from w_data and disabled lanes from memory.
REQ-026 Address >= MEM_DEPTH: write SHALL be dropped; read SHALL return all zeros with r_valid=1.
REQ-027 Clear FSM states: IDLE, CLEAR. CLEAR_ON_RESET=1: rst release enters CLEAR; counter starts at 0, writes zero to one word per cycle, increments; after writing MEM_DEPTH-1 goes to IDLE.
REQ-028 busy SHALL be 1 exactly during CLEAR state (MEM_DEPTH cycles after first edge following rst release); CLEAR_ON_RESET=0 SHALL hold busy=0 and stay in IDLE.
REQ-029 Requests with busy=1 SHALL be ignored: no memory change, no r_valid.
REQ-030 Reads in flight in the RD_LATENCY=2 pipeline when busy rises cannot occur (busy only follows reset); no further interaction required.

Reset
REQ-031 rst=1 SHALL asynchronously force r_data=0, r_valid=0, pipeline valid bits=0, clear counter=0.
REQ-032 rst=1 SHALL force FSM to CLEAR and busy=1 if CLEAR_ON_RESET=1, else IDLE and busy=0.
REQ-033 Memory array contents SHALL NOT be reset by rst directly; reset asserted mid-clear SHALL restart the sweep from address 0 after release.

Verification
REQ-034 MEM_WIDTH=16, w_be=2'b01, write 0xABCD to addr 5 over old 0x1234, read addr 5 -> r_data=0x12CD, r_valid one cycle after r_en (RD_LATENCY=1), two cycles (RD_LATENCY=2).
REQ-035 Same-cycle write 0xBEEF (w_be=2'b11) and read addr 7 holding 0x0000 -> RDW_MODE=0 returns 0x0000, RDW_MODE=1 returns 0xBEEF; later read returns 0xBEEF in both.
REQ-036 CLEAR_ON_RESET=1, MEM_DEPTH=256, memory preloaded nonzero, pulse rst -> busy high exactly 256 cycles; read during busy gives no r_valid; afterwards every address reads 0x0000.
REQ-037 Assert rst at clear count 100, release -> busy restarts, high a further full 256 cycles, all words zero after.
REQ-038 MEM_DEPTH=200, write 0xFFFF to addr 210, read addr 210 -> r_data=0x0000, r_valid=1; addr 0..199 unchanged.
REQ-039 RD_LATENCY=2, r_en high 8 consecutive cycles on addr 0..7 -> 8 consecutive r_valid pulses, data in order, none dropped.
